fetch_sequencer: RTL and testbench

Fetch-stage controller for the RV32 core. Owns the program counter, issues instruction-memory requests over a req/ack handshake, presents fetched instructions to decode with a valid/stall handshake, and applies PC redirects encoded by the branch control unit's 2-bit `branch_sel` (PC+4 / branch target / jump target). It sits between instruction memory and the decode stage. It replaces the free-running PC register when instruction memory has variable latency.

---
 rtl/fetch_sequencer_if.sv | 32 +++
 rtl/fetch_sequencer.sv | 135 +++++++++++++
 tb/tb_fetch_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: bundles the fetch controller's instruction-memory
// req/ack handshake, the decode valid/stall handshake and the branch-control
// redirect inputs.
//   master : the fetch sequencer (drives imem_req/imem_addr, if_*, flush, misalign)
//   slave  : the surrounding pipeline and memory (drives branch_*, stall, imem_ack/rdata)
interface fetch_sequencer_if #(
  parameter int XLEN = 32
);
  logic [1:0]      branch_sel;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jump_target;
  logic            stall;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            flush;
  logic            misalign;

  modport master (
    input  branch_sel, branch_target, jump_target, stall, imem_ack, imem_rdata,
    output imem_req, imem_addr, if_valid, if_instr, if_pc, flush, misalign
  );

  modport slave (
    output branch_sel, branch_target, jump_target, stall, imem_ack, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, flush, misalign
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch-stage controller. Owns the PC, issues instruction
// memory requests over req/ack, presents fetched words to decode over
// valid/stall, and applies redirects from branch_sel.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - fetch_sequencer_if.master (redirect, memory and decode handshakes)
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : misaligned redirect targets load TRAP_VEC and pulse misalign
//   undefined : target bits [1:0] forced to 00, misalign tied 0
//
// state | meaning
// BOOT  | reset state, no request, redirects ignored
// REQ   | request outstanding at addr
// HOLD  | instruction presented to decode, waiting for stall=0
// DRAIN | redirected while a request is outstanding; finish it, discard data
module fetch_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'('h100)
) (
  input logic                clk,
  input logic                rst_n,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] addr_q;
  logic [31:0]     if_instr_q;
  logic [XLEN-1:0] if_pc_q;
  logic            if_valid_q;
  logic            flush_q;
  logic            misalign_q;

  logic            redirect;
  logic [XLEN-1:0] tgt_raw;
  logic [XLEN-1:0] tgt;
  logic            tgt_mis;

  assign redirect = (bus.branch_sel != 2'b00);
  assign tgt_raw  = (bus.branch_sel == 2'b01) ? bus.branch_target : bus.jump_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign tgt_mis = |tgt_raw[1:0];
  assign tgt     = tgt_mis ? TRAP_VEC : tgt_raw;
`else
  assign tgt_mis = 1'b0;
  assign tgt     = {tgt_raw[XLEN-1:2], 2'b00};
  // TRAP_VEC and the low target bits only matter with the trap enabled.
  logic unused_trap;
  assign unused_trap = ^{TRAP_VEC, tgt_raw[1:0]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= '0;
      addr_q     <= '0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      // Any redirect seen outside BOOT is accepted and flushes younger work.
      if (redirect && state_q != BOOT) begin
        flush_q    <= 1'b1;
        misalign_q <= tgt_mis;
      end
      case (state_q)
        BOOT: begin
          pc_q    <= RESET_PC;
          addr_q  <= RESET_PC;
          state_q <= REQ;
        end
        REQ: begin
          if (redirect) begin
            pc_q <= tgt;
            if (bus.imem_ack) begin
              addr_q <= tgt;
            end else begin
              state_q <= DRAIN;
            end
          end else if (bus.imem_ack) begin
            if_instr_q <= bus.imem_rdata;
            if_pc_q    <= addr_q;
            if_valid_q <= 1'b1;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (redirect) begin
            if_valid_q <= 1'b0;
            pc_q       <= tgt;
            addr_q     <= tgt;
            state_q    <= REQ;
          end else if (!bus.stall) begin
            if_valid_q <= 1'b0;
            pc_q       <= pc_q + XLEN'(4);
            addr_q     <= pc_q + XLEN'(4);
            state_q    <= REQ;
          end
        end
        DRAIN: begin
          // Keep the stale request up until acked; newest target wins.
          if (redirect) pc_q <= tgt;
          if (bus.imem_ack) begin
            addr_q  <= redirect ? tgt : pc_q;
            state_q <= REQ;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign bus.imem_req  = (state_q == REQ) || (state_q == DRAIN);
  assign bus.imem_addr = addr_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.flush     = flush_q;
  assign bus.misalign  = misalign_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  fetch_sequencer_if #(.XLEN(32)) bus ();

  fetch_sequencer #(
    .XLEN(32), .RESET_PC(32'h0), .TRAP_VEC(32'h100)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.branch_sel    = 2'b00;
    bus.branch_target = '0;
    bus.jump_target   = '0;
    bus.stall         = 1'b0;
    bus.imem_ack      = 1'b0;
    bus.imem_rdata    = '0;
    repeat (2) step();
    chk("rst_req",      32'(bus.imem_req), 32'd0);
    chk("rst_addr",     bus.imem_addr, 32'h0);
    chk("rst_valid",    32'(bus.if_valid), 32'd0);
    chk("rst_instr",    bus.if_instr, 32'h0);
    chk("rst_pc",       bus.if_pc, 32'h0);
    chk("rst_flush",    32'(bus.flush), 32'd0);
    chk("rst_misalign", 32'(bus.misalign), 32'd0);

    // Sequential fetch with 1-cycle memory
    rst_n = 1'b1;
    step();                                   // BOOT -> REQ
    chk("f0_req",  32'(bus.imem_req), 32'd1);
    chk("f0_addr", bus.imem_addr, 32'h0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1111_1113;
    step();                                   // -> HOLD
    bus.imem_ack = 1'b0;
    chk("f0_valid", 32'(bus.if_valid), 32'd1);
    chk("f0_ifpc",  bus.if_pc, 32'h0);
    chk("f0_instr", bus.if_instr, 32'h1111_1113);
    chk("f0_hold_req", 32'(bus.imem_req), 32'd0);
    step();                                   // -> REQ @4
    chk("f1_addr", bus.imem_addr, 32'h4);
    chk("f1_req",  32'(bus.imem_req), 32'd1);
    chk("f1_valid_drop", 32'(bus.if_valid), 32'd0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2222_2223;
    step();
    bus.imem_ack = 1'b0;
    chk("f1_ifpc", bus.if_pc, 32'h4);

    // Stall 4 cycles in HOLD
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stl_valid", 32'(bus.if_valid), 32'd1);
      chk("stl_pc",    bus.if_pc, 32'h4);
      chk("stl_instr", bus.if_instr, 32'h2222_2223);
      chk("stl_req",   32'(bus.imem_req), 32'd0);
    end
    bus.stall = 1'b0;
    step();
    chk("f2_addr", bus.imem_addr, 32'h8);

    // Branch in REQ without ack, ack 3 cycles later
    bus.branch_sel = 2'b01; bus.branch_target = 32'h40;
    step();                                   // -> DRAIN
    bus.branch_sel = 2'b00;
    chk("br_flush1", 32'(bus.flush), 32'd1);
    chk("br_addr_old1", bus.imem_addr, 32'h8);
    chk("br_req1", 32'(bus.imem_req), 32'd1);
    step();
    chk("br_flush0", 32'(bus.flush), 32'd0);
    chk("br_addr_old2", bus.imem_addr, 32'h8);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    bus.imem_ack = 1'b0;
    chk("br_addr_new", bus.imem_addr, 32'h40);
    chk("br_valid", 32'(bus.if_valid), 32'd0);
    chk("br_flush_end", 32'(bus.flush), 32'd0);
    step();
    chk("br_valid2", 32'(bus.if_valid), 32'd0);

    // Branch in REQ then jump in DRAIN
    bus.branch_sel = 2'b01; bus.branch_target = 32'h40;
    step();
    chk("jd_flush1", 32'(bus.flush), 32'd1);
    bus.branch_sel = 2'b10; bus.jump_target = 32'h80;
    step();
    bus.branch_sel = 2'b00;
    chk("jd_flush2", 32'(bus.flush), 32'd1);
    chk("jd_addr_old", bus.imem_addr, 32'h40);
    step();
    chk("jd_flush3", 32'(bus.flush), 32'd0);
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    chk("jd_addr", bus.imem_addr, 32'h80);

    // Redirect with ack in REQ, then PC wrap
    bus.imem_ack = 1'b1; bus.branch_sel = 2'b01; bus.branch_target = 32'hFFFF_FFFC;
    step();
    bus.branch_sel = 2'b00;
    chk("wr_addr", bus.imem_addr, 32'hFFFF_FFFC);
    chk("wr_flush", 32'(bus.flush), 32'd1);
    chk("wr_valid", 32'(bus.if_valid), 32'd0);
    bus.imem_rdata = 32'h0000_0013;
    step();
    bus.imem_ack = 1'b0;
    chk("wr_ifpc", bus.if_pc, 32'hFFFF_FFFC);
    step();
    chk("wr_next", bus.imem_addr, 32'h0);

    // branch_sel=11 behaves as jump
    bus.imem_ack = 1'b1; bus.branch_sel = 2'b11;
    bus.branch_target = 32'h300; bus.jump_target = 32'h200;
    step();
    bus.branch_sel = 2'b00;
    chk("s11_addr", bus.imem_addr, 32'h200);

    // Misaligned redirect from HOLD
    step();                                   // ack still high -> HOLD
    bus.imem_ack = 1'b0;
    chk("mis_hold", 32'(bus.if_valid), 32'd1);
    bus.stall = 1'b1; bus.branch_sel = 2'b01; bus.branch_target = 32'h42;
    step();
    bus.branch_sel = 2'b00; bus.stall = 1'b0;
    chk("mis_flush", 32'(bus.flush), 32'd1);
    chk("mis_valid", 32'(bus.if_valid), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_addr", bus.imem_addr, 32'h100);
    chk("mis_pulse", 32'(bus.misalign), 32'd1);
`else
    chk("mis_addr", bus.imem_addr, 32'h40);
    chk("mis_pulse", 32'(bus.misalign), 32'd0);
`endif
    step();
    chk("mis_end", 32'(bus.misalign), 32'd0);
    chk("mis_flush_end", 32'(bus.flush), 32'd0);

    // Reset mid-handshake withdraws the request immediately
    chk("mid_req_pre", 32'(bus.imem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_req", 32'(bus.imem_req), 32'd0);
    chk("mid_addr", bus.imem_addr, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("re_boot_addr", bus.imem_addr, 32'h0);
    chk("re_boot_req", 32'(bus.imem_req), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
